dmem_apb_master: RTL and testbench
==================================

# dmem_apb_master

Data-memory bus master placed directly downstream of the RV32I single-cycle datapath. It takes the datapath's memory request (ALU result as address, lane-aligned store data, byte enables) and performs one APB4 transfer per load/store. While the transfer is in flight it asserts a stall that freezes PC and register-file write. It returns the raw 32-bit read word to the datapath's load path.

## Interface

Reset is asynchronous and active-low; `clk` is the single clock.

Parameters:
- `ADDR_W`, 32: APB address width.
- `TIMEOUT_CYCLES`, 255: maximum ACCESS wait cycles. Used only with `DMEM_APB_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `req_valid` in 1: load or store present this instruction (MemRead | MemWrite).
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address (datapath ALU_result).
- `req_wdata` in 32: lane-aligned store data (datapath RAM_w_data).
- `req_be` in 4: byte enables (datapath byte_enable).
- `stall` out 1: hold PC, suppress RegWrite.
- `rdata` out 32: registered read word, feeds RAM_r_data.
- `bus_err` out 1: one-cycle pulse in DONE on PSLVERR or timeout.
- `paddr` out ADDR_W: APB address.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB write.
- `pwdata` out 32: APB write data.
- `pstrb` out 4: APB strobes.
- `prdata` in 32: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB slave error.

## Operation

- FSM states: IDLE, SETUP, ACCESS, DONE.
- **IDLE:**
  - `stall` = `req_valid`, combinational.
  - On `req_valid`, capture the request registers and go to SETUP:
    - `paddr` = {req_addr[ADDR_W-1:2], 2'b00}.
    - `pwrite`, `pwdata` from the request.
    - `pstrb` = req_write ? req_be : 4'b0000.
- **SETUP:** `psel`=1, `penable`=0, `stall`=1. Go to ACCESS unconditionally.
- **ACCESS:**
  - `psel`=1, `penable`=1, `stall`=1.
  - On `pready`: latch `prdata` into `rdata` (loads only; `rdata` holds its value on stores), record `pslverr`, go to DONE.
- **DONE:**
  - `psel`=0, `stall`=0. The core commits this cycle using `rdata`.
  - `bus_err` pulses if an error was recorded.
  - Go to IDLE unconditionally; the still-asserted `req_valid` of the committing instruction is not reissued.
- `paddr`/`pwrite`/`pwdata`/`pstrb` stay stable from SETUP through ACCESS.
- A load with PSLVERR: `rdata` = `prdata` as returned. A store with PSLVERR: no retry.
- Misaligned addresses are not checked here; low two address bits are dropped.

## Timing

- Reset values (asynchronous, immediate):
  - state = IDLE.
  - `psel`, `penable`, `pwrite`, `bus_err` = 0.
  - `paddr`, `pwdata`, `rdata` = 0; `pstrb` = 0.
- `stall` is combinational from state and `req_valid`.
- Zero-wait slave: request seen in cycle 0 (IDLE), SETUP cycle 1, ACCESS cycle 2, DONE cycle 3. That is 3 stall cycles per access.
- Each `pready`=0 cycle in ACCESS adds one stall cycle.
- Back-to-back memory instructions: DONE → IDLE → SETUP, giving a minimum 4-cycle issue spacing.
- Reset asserted mid-transfer aborts the transfer: `psel`/`penable` drop asynchronously and no DONE is produced.

## Configuration

- `DMEM_APB_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on SETUP and increments each ACCESS cycle with `pready`=0.
  - When the count reaches `TIMEOUT_CYCLES`, go to DONE with an error recorded; `rdata` = 32'h0000_0000 for loads.
- Undefined: no counter. ACCESS waits on `pready` indefinitely.

## Structure

- Package `dmem_bus_pkg`:
  - `dmem_state_e` enum (IDLE, SETUP, ACCESS, DONE).
  - Constants `APB_DATA_W`=32 and `APB_STRB_W`=4.
  - Packed struct `dmem_req_t` (write, addr, wdata, be).
- Sub-module `apb_timeout_counter` holds the watchdog; instantiate it only under `DMEM_APB_TIMEOUT_EN`.

## Test plan

- **Store, zero-wait:** req_valid=1, write=1, addr=0x1000_0006, wdata=0x00AB_0000, be=4'b0100.
  - Expect paddr=0x1000_0004, pstrb=4'b0100, pwdata=0x00AB_0000.
  - Expect stall high for exactly 3 cycles, then low in DONE.
- **Load, 2 wait states:** addr=0x0000_0010, prdata=0xDEAD_BEEF on the `pready` cycle.
  - Expect 5 stall cycles, pstrb=4'b0000, rdata=0xDEAD_BEEF in DONE.
- **Back-to-back:** load then store on consecutive instructions.
  - Expect exactly two APB transfers with SETUP starts 4 cycles apart; the first request is never reissued.
- **PSLVERR on load:** pslverr=1 with pready.
  - Expect a one-cycle `bus_err` pulse in DONE and stall released.
- **Reset mid-ACCESS:** drive rst low while pready=0.
  - Expect psel/penable/stall=0 in the same cycle, state IDLE, rdata=0.
- **Timeout (macro defined, TIMEOUT_CYCLES=4):** pready held 0.
  - Expect DONE after 4 ACCESS cycles, bus_err=1, rdata=0.

Source files
------------

// File: rtl/dmem_bus_pkg.sv
// Shared types and constants for the data-memory APB master.
// The watchdog in apb_timeout_counter is built only with DMEM_APB_TIMEOUT_EN.
package dmem_bus_pkg;

   localparam int unsigned APB_DATA_W = 32;
   localparam int unsigned APB_STRB_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      DONE
   } dmem_state_e;

   typedef struct packed {
      logic                  write;
      logic [31:0]           addr;
      logic [APB_DATA_W-1:0] wdata;
      logic [APB_STRB_W-1:0] be;
   } dmem_req_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase watchdog; compiled only when DMEM_APB_TIMEOUT_EN is defined.
// expired is asserted on the wait cycle whose increment would reach LIMIT.
`ifdef DMEM_APB_TIMEOUT_EN
module apb_timeout_counter #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int unsigned RAW_W = $clog2(LIMIT + 1);
   localparam int unsigned CNT_W = (RAW_W < 8) ? 8 : ((RAW_W > 16) ? 16 : RAW_W);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = inc && (count == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/dmem_apb_master.sv
// Data-memory APB4 master: one transfer per load/store, stalls the core meanwhile.
// Define DMEM_APB_TIMEOUT_EN to bound the ACCESS wait to TIMEOUT_CYCLES.
module dmem_apb_master
   import dmem_bus_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [31:0]           req_addr,
   input  logic [APB_DATA_W-1:0] req_wdata,
   input  logic [APB_STRB_W-1:0] req_be,
   output logic                  stall,
   output logic [APB_DATA_W-1:0] rdata,
   output logic                  bus_err,
   output logic [ADDR_W-1:0]     paddr,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [APB_DATA_W-1:0] pwdata,
   output logic [APB_STRB_W-1:0] pstrb,
   input  logic [APB_DATA_W-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   dmem_state_e state;
   dmem_req_t   req;
   logic        timeout;
   logic        unused_bits;

   assign req = '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};
   // Word-aligned bus: the byte offset is already encoded in the strobes.
   assign unused_bits = ^req.addr[1:0];

`ifdef DMEM_APB_TIMEOUT_EN
   apb_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == SETUP),
      .inc     ((state == ACCESS) && !pready),
      .expired (timeout)
   );
`else
   localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   always_comb begin
      stall = 1'b1;
      unique case (state)
         IDLE:    stall = req_valid;
         DONE:    stall = 1'b0;
         default: stall = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         psel    <= 1'b0;
         penable <= 1'b0;
         pwrite  <= 1'b0;
         bus_err <= 1'b0;
         paddr   <= '0;
         pwdata  <= '0;
         pstrb   <= '0;
         rdata   <= '0;
      end else begin
         bus_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  paddr  <= {req.addr[ADDR_W-1:2], 2'b00};
                  pwrite <= req.write;
                  pwdata <= req.wdata;
                  pstrb  <= req.write ? req.be : '0;
                  psel   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (pready || timeout) begin
                  psel    <= 1'b0;
                  penable <= 1'b0;
                  if (!pwrite) begin
                     rdata <= pready ? prdata : '0;
                  end
                  bus_err <= pready ? pslverr : 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               // The committing instruction's req_valid is still high here; ignore it.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_apb_master.sv
// Scoreboard bench for dmem_apb_master: driver pushes expectations, monitor checks at DONE.
module tb_dmem_apb_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        stall;
   logic [31:0] rdata;
   logic        bus_err;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata = '0;
   logic        pready = 1'b0;
   logic        pslverr = 1'b0;

   dmem_apb_master #(
      .ADDR_W         (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .stall     (stall),
      .rdata     (rdata),
      .bus_err   (bus_err),
      .paddr     (paddr),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] paddr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      int          stall_cycles;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   setup_times[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   int          slv_wait = 0;
   logic [31:0] slv_rdata = '0;
   logic        slv_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // APB slave: pready rises after slv_wait ACCESS cycles.
   int acc_cnt = 0;
   always @(posedge clk) begin
      #1;
      if (psel && penable) begin
         pready  = (acc_cnt == slv_wait);
         prdata  = pready ? slv_rdata : 32'h0;
         pslverr = pready ? slv_err : 1'b0;
         acc_cnt++;
      end else begin
         acc_cnt = 0;
         pready  = 1'b0;
         prdata  = 32'h0;
         pslverr = 1'b0;
      end
   end

   // Monitor: APB fields at transfer completion, response at the DONE cycle.
   int run = 0;
   bit err_clear_chk = 0;
   always @(negedge clk) begin
      if (!rst) begin
         run = 0;
         err_clear_chk = 0;
      end else begin
         if (psel && !penable) setup_times.push_back(cyc);
         if (psel && penable && pready) begin
            if (exp_q.size() == 0) begin
               check("apb_unexpected", 32'd1, 32'd0);
            end else begin
               check("pwrite", {31'd0, pwrite}, {31'd0, exp_q[0].wr});
               check("paddr", paddr, exp_q[0].paddr);
               check("pstrb", {28'd0, pstrb}, {28'd0, exp_q[0].strb});
               check("pwdata", pwdata, exp_q[0].wdata);
            end
         end
         if (err_clear_chk) begin
            check("bus_err_pulse_end", {31'd0, bus_err}, 32'd0);
            err_clear_chk = 0;
         end
         if (stall) begin
            run++;
         end else if (run > 0) begin
            if (exp_q.size() == 0) begin
               check("done_unexpected", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("stall_cycles", run, e.stall_cycles);
               check("rdata", rdata, e.rdata);
               check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
            end
            run = 0;
            err_clear_chk = 1;
         end
      end
   end

   task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be);
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_be    = be;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!stall) begin
            seen = 1;
            break;
         end
      end
      if (!seen) check("wait_done", 32'd0, 32'd1);
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int wt, input logic [31:0] srd,
                        input logic serr, input logic [31:0] e_paddr, input logic [3:0] e_strb,
                        input int e_stall, input logic [31:0] e_rdata, input logic e_err);
      exp_t e;
      e = '{wr: wr, paddr: e_paddr, strb: e_strb, wdata: wd, stall_cycles: e_stall,
            rdata: e_rdata, err: e_err};
      exp_q.push_back(e);
      slv_wait  = wt;
      slv_rdata = srd;
      slv_err   = serr;
      drive_req(wr, addr, wd, be);
      wait_done();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         req_valid = 1'b0;
      end
   endtask

   initial begin
      int n0;
      #12;
      check("rst_psel", {31'd0, psel}, 32'd0);
      check("rst_penable", {31'd0, penable}, 32'd0);
      check("rst_pwrite", {31'd0, pwrite}, 32'd0);
      check("rst_bus_err", {31'd0, bus_err}, 32'd0);
      check("rst_paddr", paddr, 32'd0);
      check("rst_pwdata", pwdata, 32'd0);
      check("rst_pstrb", {28'd0, pstrb}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle(2);

      // Store, zero-wait; rdata must hold despite prdata activity.
      issue(1'b1, 32'h1000_0006, 32'h00AB_0000, 4'b0100, 0, 32'h1234_5678, 1'b0,
            32'h1000_0004, 4'b0100, 3, 32'h0, 1'b0);
      idle(2);
      // Load, two wait states.
      issue(1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 4'b1111, 2, 32'hDEAD_BEEF, 1'b0,
            32'h0000_0010, 4'b0000, 5, 32'hDEAD_BEEF, 1'b0);
      idle(2);
`ifdef DMEM_APB_TIMEOUT_EN
      // Timeout: slave never ready; four ACCESS cycles then error with zeroed rdata.
      issue(1'b0, 32'h0000_0050, 32'h0, 4'b1111, 1000, 32'h7777_7777, 1'b0,
            32'h0000_0050, 4'b0000, 6, 32'h0, 1'b1);
      idle(2);
`endif
      // Back-to-back load then store.
      n0 = setup_times.size();
      issue(1'b0, 32'h0000_0203, 32'h0, 4'b1111, 0, 32'hCAFE_F00D, 1'b0,
            32'h0000_0200, 4'b0000, 3, 32'hCAFE_F00D, 1'b0);
      issue(1'b1, 32'h0000_0300, 32'h1122_3344, 4'b1111, 0, 32'h9999_9999, 1'b0,
            32'h0000_0300, 4'b1111, 3, 32'hCAFE_F00D, 1'b0);
      idle(4);
      check("b2b_transfers", setup_times.size() - n0, 32'd2);
      if (setup_times.size() >= n0 + 2)
         check("b2b_spacing", setup_times[n0+1] - setup_times[n0], 32'd4);
      else
         check("b2b_spacing", 32'd0, 32'd4);
      // PSLVERR on load.
      issue(1'b0, 32'h0000_0020, 32'h0, 4'b1111, 0, 32'h0BAD_0BAD, 1'b1,
            32'h0000_0020, 4'b0000, 3, 32'h0BAD_0BAD, 1'b1);
      idle(2);

      // Reset mid-ACCESS; no expectation pushed, so any DONE would be flagged.
      slv_wait = 1000;
      drive_req(1'b0, 32'h0000_0040, 32'h0, 4'b1111);
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_access", {30'd0, psel, penable}, 32'd3);
      rst = 1'b0;
      req_valid = 1'b0;
      #1;
      check("mid_rst_psel", {31'd0, psel}, 32'd0);
      check("mid_rst_penable", {31'd0, penable}, 32'd0);
      check("mid_rst_stall", {31'd0, stall}, 32'd0);
      check("mid_rst_rdata", rdata, 32'd0);
      check("mid_rst_state", {30'd0, dut.state}, {30'd0, dmem_bus_pkg::IDLE});
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle(3);
      check("post_rst_bus_err", {31'd0, bus_err}, 32'd0);
      issue(1'b0, 32'h0000_0060, 32'h0, 4'b1111, 1, 32'h5555_AAAA, 1'b0,
            32'h0000_0060, 4'b0000, 4, 32'h5555_AAAA, 1'b0);
      idle(4);
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
